memory_sp_m: RTL and testbench

Clocked single-port RAM with separate read and write data buses, per-byte write enables and a req/ready handshake. Read latency is configurable, and a read-valid strobe marks returning data. After reset, and on request, a hardware clear engine zeroes every word. This block replaces the combinational tri-state register-file memory wherever storage sits on a synchronous datapath.

---
 rtl/memory_sp_m.sv | 146 ++++++++++++++
 tb/tb_memory_sp_m.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_sp_m.sv
// Single-port synchronous RAM with separate read/write data buses, per-byte write
// enables, req/ready handshake, a configurable read latency and a hardware clear
// engine that zeroes every word after reset and on request.
module memory_sp_m #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 5,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1,
  parameter int BEW    = DWIDTH / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [BEW-1:0]    be,
  input  logic              clr_req,
  output logic              ready,
  output logic [DWIDTH-1:0] rdata,
  output logic              rvalid,
  output logic              rerr,
  output logic              init_done
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_DRAIN} state_t;

  localparam logic [AWIDTH:0]   DEPTH_EXT = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_WORD = AWIDTH'(DEPTH - 1);

  state_t              state;
  logic [AWIDTH-1:0]   clr_cnt;
  logic [DWIDTH-1:0]   mem [DEPTH];

  logic                accept;
  logic                acc_wr;
  logic                acc_rd;
  logic                in_range;
  logic                rd_busy;
  logic [DWIDTH-1:0]   rd_word;

  logic [RD_LAT-1:0]   vld_p;
  logic [RD_LAT-1:0]   err_p;
  logic [DWIDTH-1:0]   dat_p [RD_LAT];

  // Replace the enabled bytes of a stored word with the incoming write data.
  function automatic logic [DWIDTH-1:0] merge_bytes(input logic [DWIDTH-1:0] old_word,
                                                    input logic [DWIDTH-1:0] new_word,
                                                    input logic [BEW-1:0]    byte_en);
    logic [DWIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < BEW; b++) begin
      if (byte_en[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // ready is registered and only ever high in IDLE, so accept implies IDLE.
  assign accept   = req && ready;
  assign acc_wr   = accept && we;
  assign acc_rd   = accept && !we;
  assign in_range = ({1'b0, addr} < DEPTH_EXT);
  assign rd_word  = in_range ? mem[addr] : '0;
  assign rd_busy  = |vld_p;

  // Storage: the clear engine owns the array in INIT, accepted writes otherwise.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[clr_cnt] <= '0;
    end else if (acc_wr && in_range) begin
      mem[addr] <= merge_bytes(mem[addr], wdata, be);
    end
  end

  // Control FSM: clear sweep, normal service, and draining reads before a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      clr_cnt   <= '0;
      ready     <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (clr_cnt == LAST_WORD) begin
            state     <= S_IDLE;
            clr_cnt   <= '0;
            ready     <= 1'b1;
            init_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + AWIDTH'(1);
          end
        end
        S_IDLE: begin
          if (clr_req) begin
            ready   <= 1'b0;
            clr_cnt <= '0;
            state   <= (rd_busy || acc_rd) ? S_DRAIN : S_INIT;
          end
        end
        S_DRAIN: begin
          if (!rd_busy) begin
            state   <= S_INIT;
            clr_cnt <= '0;
          end
        end
        default: begin
          state   <= S_INIT;
          clr_cnt <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  // Read control pipeline: valid/error flags travel with the captured data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p  <= '0;
      err_p  <= '0;
      rvalid <= 1'b0;
      rerr   <= 1'b0;
      rdata  <= '0;
    end else begin
      vld_p[0] <= acc_rd;
      err_p[0] <= acc_rd && !in_range;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        err_p[i] <= err_p[i-1];
      end
      rvalid <= vld_p[RD_LAT-1];
      rerr   <= vld_p[RD_LAT-1] && err_p[RD_LAT-1];
      if (vld_p[RD_LAT-1]) rdata <= dat_p[RD_LAT-1];
    end
  end

  // Read data pipeline: word is captured on the accept edge so later writes or a
  // clear cannot disturb a read already in flight.
  always_ff @(posedge clk) begin
    dat_p[0] <= rd_word;
    for (int i = 1; i < RD_LAT; i++) begin
      dat_p[i] <= dat_p[i-1];
    end
  end

endmodule

// File: tb/tb_memory_sp_m.sv
// Self-checking bench for memory_sp_m: directed table, clear/drain and reset
// corner sequences, and randomized traffic against a word-array reference model.
module tb_memory_sp_m;

  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int DEPTH  = 20;
  localparam int RD_LAT = 3;
  localparam int BW     = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [BW-1:0] be;
  logic          clr_req;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rerr;
  logic          init_done;

  memory_sp_m #(
    .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .clr_req(clr_req), .ready(ready), .rdata(rdata), .rvalid(rvalid),
    .rerr(rerr), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          err;
  } rd_t;

  rd_t           exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] last_rdata;
  int            cyc;
  int            total;
  int            bad;
  vec_t          tbl [15];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic drive_idle();
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; clr_req = 1'b0;
  endtask

  // One clock: predict the effect of this edge, then check outputs just after it.
  task automatic step(input bit ovr = 1'b0, input logic [DW-1:0] od = '0, input logic oe = 1'b0);
    logic          acc;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] b;
    rd_t           r;
    acc = req && ready && rst_n;
    w = we; a = addr; d = wdata; b = be;
    @(posedge clk);
    cyc++;
    if (acc) begin
      if (w) begin
        if (int'(a) < DEPTH)
          for (int k = 0; k < BW; k++) if (b[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
      end else begin
        r.due  = cyc + RD_LAT;
        r.err  = (int'(a) >= DEPTH);
        r.data = r.err ? '0 : ref_mem[a];
        if (ovr) begin
          r.data = od;
          r.err  = oe;
        end
        exp_q.push_back(r);
      end
    end
    #1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      check("rvalid", 32'(rvalid), 32'd1);
      check("rdata", rdata, r.data);
      check("rerr", 32'(rerr), 32'(r.err));
      last_rdata = r.data;
    end else begin
      check("no_rvalid", 32'(rvalid), 32'd0);
      check("rerr_idle", 32'(rerr), 32'd0);
      check("rdata_hold", rdata, last_rdata);
    end
  endtask

  // After reset release, ready/init_done must rise on exactly the DEPTH-th edge.
  task automatic init_check();
    logic early;
    early = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      if (i < DEPTH && (ready || init_done)) early = 1'b1;
    end
    check("init_early", 32'(early), 32'd0);
    check("init_ready", 32'(ready), 32'd1);
    check("init_done", 32'(init_done), 32'd1);
    clear_model();
  endtask

  initial begin
    int n;
    logic dip;
    total = 0; bad = 0; cyc = 0; last_rdata = '0;
    clear_model();
    drive_idle();
    rst_n = 1'b0;

    tbl[0]  = '{1'b1, 5'd2,  32'h11223344, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 5'd2,  32'hFFFFFFFF, 4'h5, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 5'd2,  32'h0,        4'h0, 32'h11FF33FF, 1'b0};
    tbl[3]  = '{1'b1, 5'd5,  32'h000000A5, 4'h1, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 5'd5,  32'h0,        4'h0, 32'h000000A5, 1'b0};
    tbl[5]  = '{1'b1, 5'd25, 32'h0000007E, 4'hF, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 5'd25, 32'h0,        4'h0, 32'h0,        1'b1};
    tbl[7]  = '{1'b1, 5'd19, 32'hCAFEBABE, 4'hF, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 5'd19, 32'h0,        4'h0, 32'hCAFEBABE, 1'b0};
    tbl[9]  = '{1'b1, 5'd19, 32'h00000000, 4'h0, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 5'd19, 32'h0,        4'h0, 32'hCAFEBABE, 1'b0};
    tbl[11] = '{1'b0, 5'd20, 32'h0,        4'h0, 32'h0,        1'b1};
    tbl[12] = '{1'b0, 5'd0,  32'h0,        4'h0, 32'h0,        1'b0};
    tbl[13] = '{1'b1, 5'd0,  32'hDEADBEEF, 4'hA, 32'h0,        1'b0};
    tbl[14] = '{1'b0, 5'd0,  32'h0,        4'h0, 32'hDE00BE00, 1'b0};

    // Reset values, then initial clear sweep.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rerr", 32'(rerr), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    rst_n = 1'b1;
    init_check();

    // Every address reads zero after the sweep; out-of-range flags rerr.
    for (int a = 0; a < 32; a++) begin
      req = 1'b1; we = 1'b0; addr = AW'(a);
      step();
    end

    // Directed table, applied back to back.
    for (int i = 0; i < 15; i++) begin
      req = 1'b1; we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].wdata; be = tbl[i].be;
      step(!tbl[i].we, tbl[i].exp_data, tbl[i].exp_err);
    end
    drive_idle();
    repeat (RD_LAT + 1) step();

    // Clear with reads in flight: pre-clear data returns, then a full sweep.
    for (int a = 1; a <= 3; a++) begin
      req = 1'b1; we = 1'b1; addr = AW'(a); wdata = 32'h5A5A0000 | a; be = 4'hF;
      step();
    end
    for (int a = 1; a <= 3; a++) begin
      req = 1'b1; we = 1'b0; addr = AW'(a);
      step();
    end
    drive_idle();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("clr_ready_drop", 32'(ready), 32'd0);
    // Requests while not ready must be ignored.
    req = 1'b1; we = 1'b1; addr = 5'd1; wdata = 32'hFFFFFFFF; be = 4'hF;
    n = 0;
    dip = 1'b0;
    while (!ready && n < 200) begin
      n++;
      step();
      if (!init_done) dip = 1'b1;
      if (n == 10) we = 1'b0;
    end
    drive_idle();
    check("clr_timeout", 32'(n < 200), 32'd1);
    check("clr_low_min", 32'(n >= DEPTH), 32'd1);
    check("clr_low_max", 32'(n <= DEPTH + RD_LAT + 1), 32'd1);
    check("clr_init_done_kept", 32'(dip), 32'd0);
    clear_model();
    for (int a = 1; a <= 3; a++) begin
      req = 1'b1; we = 1'b0; addr = AW'(a);
      step();
    end
    drive_idle();
    repeat (RD_LAT + 1) step();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      req   = ($urandom_range(0, 3) != 0);
      we    = $urandom_range(0, 1) == 1;
      addr  = AW'($urandom_range(0, 31));
      wdata = $urandom;
      be    = BW'($urandom_range(0, 15));
      step();
    end
    drive_idle();
    repeat (RD_LAT + 1) step();

    // Reset during a read burst: rvalid drops at once and stays low through re-init.
    for (int a = 0; a < 6; a++) begin
      req = 1'b1; we = 1'b0; addr = AW'(a);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    drive_idle();
    exp_q.delete();
    last_rdata = '0;
    repeat (2) @(posedge clk);
    cyc += 2;
    #1;
    rst_n = 1'b1;
    init_check();
    for (int a = 0; a < 4; a++) begin
      req = 1'b1; we = 1'b0; addr = AW'(a);
      step();
    end
    drive_idle();
    repeat (RD_LAT + 1) step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
